// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter/sequencer in front of a single-port data memory.
// Define MEM_ARB_CNT_EN to add saturating per-port grant counters (m0_grant_cnt/m1_grant_cnt).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData,
  output logic              busy
`ifdef MEM_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0]  m0_grant_cnt,
  output logic [CNT_W-1:0]  m1_grant_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_prio;
  logic              r_winner;
  logic              r_we;
  logic              w_anyReq;
  logic              w_winner;
  logic              w_winWe;
  logic [ADDR_W-1:0] w_winAddr;
  logic [DATA_W-1:0] w_winWdata;

  // r_prio names the port that wins a tie; it always points away from the last grant.
  always_comb begin
    w_anyReq = m0_req | m1_req;
    w_winner = 1'b0;
    if (m0_req && m1_req) begin
      w_winner = r_prio;
    end else if (m1_req) begin
      w_winner = 1'b1;
    end
    w_winWe    = w_winner ? m1_we    : m0_we;
    w_winAddr  = w_winner ? m1_addr  : m0_addr;
    w_winWdata = w_winner ? m1_wdata : m0_wdata;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_anyReq) w_nextState = S_GRANT;
      S_GRANT: w_nextState = S_RESP;
      S_RESP:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Outputs are registered so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio        <= 1'b0;
      r_winner      <= 1'b0;
      r_we          <= 1'b0;
      m0_ack        <= 1'b0;
      m1_ack        <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
      mem_address   <= '0;
      mem_writeData <= '0;
      mem_memWrite  <= 1'b0;
      mem_memRead   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_winner      <= w_winner;
            r_we          <= w_winWe;
            r_prio        <= ~w_winner;
            mem_address   <= w_winAddr;
            mem_writeData <= w_winWdata;
            mem_memWrite  <= w_winWe;
            mem_memRead   <= ~w_winWe;
            busy          <= 1'b1;
          end
        end
        S_GRANT: begin
          mem_memWrite <= 1'b0;
          mem_memRead  <= 1'b0;
          if (r_winner) begin
            m1_ack <= 1'b1;
            if (!r_we) m1_rdata <= mem_readData;
          end else begin
            m0_ack <= 1'b1;
            if (!r_we) m0_rdata <= mem_readData;
          end
        end
        S_RESP: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_CNT_EN
  // Counters advance on the same edge that raises the winner's ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
    end else if (r_state == S_GRANT) begin
      if (!r_winner && (m0_grant_cnt != {CNT_W{1'b1}})) m0_grant_cnt <= m0_grant_cnt + 1'b1;
      if (r_winner && (m1_grant_cnt != {CNT_W{1'b1}}))  m1_grant_cnt <= m1_grant_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with a small behavioural data memory.
// Define MEM_ARB_CNT_EN for both files to also exercise the grant counters.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_memWrite, mem_memRead, busy;
`ifdef MEM_ARB_CNT_EN
  logic [1:0]  m0_grant_cnt, m1_grant_cnt;
`endif

  int testsRun  = 0;
  int failCount = 0;
  int writeCycles = 0;
  int readCycles  = 0;
  int bothRdWr    = 0;
  int bothAck     = 0;
  int ackCount    = 0;
  logic [31:0] tbMem [0:15];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData), .busy(busy)
`ifdef MEM_ARB_CNT_EN
    , .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: combinational read, write on the rising edge.
  assign mem_readData = tbMem[mem_address[3:0]];
  always @(posedge clk) begin
    if (mem_memWrite) tbMem[mem_address[3:0]] <= mem_writeData;
  end

  always @(negedge clk) begin
    if (mem_memWrite) writeCycles++;
    if (mem_memRead) readCycles++;
    if (mem_memWrite && mem_memRead) bothRdWr++;
    if (m0_ack && m1_ack) bothAck++;
    if (m0_ack || m1_ack) ackCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  // One complete access from a single port; returns read data, called and returns at a negedge.
  task automatic runAccess(input bit port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
    bit seen = 0;
    rdata = '0;
    applyStimulus(port, we, addr, wdata);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (port ? m1_ack : m0_ack) begin
        seen  = 1;
        rdata = port ? m1_rdata : m0_rdata;
      end
    end
    if (port) m1_req = 1'b0; else m0_req = 1'b0;
    if (!seen) checkOutput("accessTimeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int wBefore, rBefore, aBefore, cyc, m0Cyc, m1Cyc, grants;
    bit order [0:5];
    for (int i = 0; i < 16; i++) tbMem[i] = '0;
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("rstBusy", {63'd0, busy}, 64'd0);
    checkOutput("rstAcks", {62'd0, m0_ack, m1_ack}, 64'd0);
    checkOutput("rstMemCmd", {62'd0, mem_memWrite, mem_memRead}, 64'd0);
    checkOutput("rstMemAddr", {32'd0, mem_address}, 64'd0);
    @(negedge clk);

    // Test 2: m0 write, cycle-exact latency
    wBefore = writeCycles;
    applyStimulus(0, 1'b1, 32'd7, 32'hE0000000);
    @(negedge clk);
    checkOutput("t2GrantCmd", {62'd0, mem_memWrite, mem_memRead}, 64'd2);
    checkOutput("t2GrantAddr", {32'd0, mem_address}, 64'd7);
    checkOutput("t2GrantWdata", {32'd0, mem_writeData}, 64'hE0000000);
    checkOutput("t2GrantBusyAck", {62'd0, busy, m0_ack}, 64'd2);
    @(negedge clk);
    checkOutput("t2RespAcks", {62'd0, m0_ack, m1_ack}, 64'd2);
    checkOutput("t2RespCmd", {62'd0, mem_memWrite, mem_memRead}, 64'd0);
    m0_req = 1'b0;
    @(negedge clk);
    checkOutput("t2IdleBusyAck", {62'd0, busy, m0_ack}, 64'd0);
    checkOutput("t2WriteCycles", 64'(writeCycles - wBefore), 64'd1);

    // Test 3: m1 read-back of address 7
    rBefore = readCycles;
    applyStimulus(1, 1'b0, 32'd7, 32'd0);
    @(negedge clk);
    checkOutput("t3GrantCmd", {62'd0, mem_memWrite, mem_memRead}, 64'd1);
    checkOutput("t3GrantAddr", {32'd0, mem_address}, 64'd7);
    @(negedge clk);
    checkOutput("t3RespAcks", {62'd0, m0_ack, m1_ack}, 64'd1);
    checkOutput("t3Rdata", {32'd0, m1_rdata}, 64'hE0000000);
    checkOutput("t3OtherRdataHeld", {32'd0, m0_rdata}, 64'd0);
    m1_req = 1'b0;
    @(negedge clk);
    checkOutput("t3ReadCycles", 64'(readCycles - rBefore), 64'd1);

    // Test 1: m0 access leaves the pointer on m1, then reset during m1's grant
    runAccess(0, 1'b0, 32'd7, 32'd0, rd);
    checkOutput("t1m0Read", {32'd0, rd}, 64'hE0000000);
    aBefore = ackCount;
    applyStimulus(0, 1'b0, 32'd7, 32'd0);
    applyStimulus(1, 1'b1, 32'd9, 32'h12345678);
    @(negedge clk);
    checkOutput("t1TieGoesM1", {32'd0, mem_address}, 64'd9);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t1RstBusy", {63'd0, busy}, 64'd0);
    checkOutput("t1RstMemCmd", {62'd0, mem_memWrite, mem_memRead}, 64'd0);
    checkOutput("t1RstMemBus", {mem_address, mem_writeData}, 64'd0);
    checkOutput("t1RstRdata", {m0_rdata, m1_rdata}, 64'd0);
    checkOutput("t1NoAckAborted", 64'(ackCount - aBefore), 64'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Test 4: simultaneous writes, m0 must win the first tie after reset
    applyStimulus(0, 1'b1, 32'd6, 32'hFFFFFFFF);
    applyStimulus(1, 1'b1, 32'd8, 32'hAAAAAAAA);
    cyc = 0; m0Cyc = -1; m1Cyc = -1;
    while ((m0_req || m1_req) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (m0_ack) begin m0Cyc = cyc; m0_req = 1'b0; end
      if (m1_ack) begin m1Cyc = cyc; m1_req = 1'b0; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    checkOutput("t4m0AckCycle", 64'(m0Cyc), 64'd2);
    checkOutput("t4m1AckCycle", 64'(m1Cyc), 64'd5);
    runAccess(0, 1'b0, 32'd6, 32'd0, rd);
    checkOutput("t4ReadAddr6", {32'd0, rd}, 64'hFFFFFFFF);
    runAccess(1, 1'b0, 32'd8, 32'd0, rd);
    checkOutput("t4ReadAddr8", {32'd0, rd}, 64'hAAAAAAAA);

    // Test 5: both hold requests continuously for six grants
    applyStimulus(0, 1'b0, 32'd6, 32'd0);
    applyStimulus(1, 1'b0, 32'd8, 32'd0);
    grants = 0;
    for (int i = 0; i < 40 && grants < 6; i++) begin
      @(negedge clk);
      if (m0_ack) begin order[grants] = 1'b0; grants++; end
      else if (m1_ack) begin order[grants] = 1'b1; grants++; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t5GrantCount", 64'(grants), 64'd6);
    for (int i = 0; i < grants; i++)
      checkOutput($sformatf("t5Order%0d", i), {63'd0, order[i]}, 64'(i % 2));
    checkOutput("t5Rdata", {m0_rdata, m1_rdata}, {32'hFFFFFFFF, 32'hAAAAAAAA});
    checkOutput("neverRdAndWr", 64'(bothRdWr), 64'd0);
    checkOutput("neverTwoAcks", 64'(bothAck), 64'd0);

`ifdef MEM_ARB_CNT_EN
    // Test 6: two-bit counters saturate at 3
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("t6CntReset", {60'd0, m0_grant_cnt, m1_grant_cnt}, 64'd0);
    for (int i = 0; i < 5; i++) runAccess(0, 1'b0, 32'd1, 32'd0, rd);
    checkOutput("t6m0Cnt", {62'd0, m0_grant_cnt}, 64'd3);
    checkOutput("t6m1Cnt", {62'd0, m1_grant_cnt}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
